// File: rtl/rng_roll_scheduler.sv
// rng_roll_scheduler: sequences a decelerating LFSR roll. It issues one-cycle
// step enables whose period doubles every phase, then captures the LFSR value
// as the roll result once the last phase (or an early stop) has finished.
module rng_roll_scheduler #(
  parameter int CNT_W       = 24,
  parameter int PHASE_LEN   = 10000000,
  parameter int BASE_PERIOD = 312500,
  parameter int NUM_PHASES  = 5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic [3:0] i_rand,
  output logic       o_step,
  output logic       o_busy,
  output logic [2:0] o_phase,
  output logic [3:0] o_result,
  output logic       o_done
);

  localparam longint unsigned MaxPeriod = 64'(BASE_PERIOD) << (NUM_PHASES - 1);
  localparam longint unsigned CntMax    = (64'd1 << CNT_W) - 64'd1;

  // Reject parameter sets whose longest period or phase length overflow the counters.
  if ((NUM_PHASES < 1) || (NUM_PHASES > 8) || (BASE_PERIOD < 1) || (PHASE_LEN < 1) ||
      (MaxPeriod > CntMax) || (64'(PHASE_LEN) > CntMax)) begin : g_param_check
    $fatal(1, "rng_roll_scheduler: counter width too small or NUM_PHASES out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_phase, w_phase_nxt;
  logic [CNT_W-1:0] r_phase_cnt, w_phase_cnt_nxt;
  logic [CNT_W-1:0] r_period_cnt, w_period_cnt_nxt;
  logic [3:0]       r_result, w_result_nxt;
  logic             r_done, w_done_nxt;

  logic [CNT_W-1:0] w_period_last;
  logic             w_phase_end;
  logic             w_period_end;

  assign w_period_last = (CNT_W'(BASE_PERIOD) << r_phase) - CNT_W'(1);
  assign w_phase_end   = (r_phase_cnt == CNT_W'(PHASE_LEN - 1));
  assign w_period_end  = (r_period_cnt == w_period_last);

  // State and counter registers; reset aborts any roll without a done pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_phase      <= 3'd0;
      r_phase_cnt  <= {CNT_W{1'b0}};
      r_period_cnt <= {CNT_W{1'b0}};
      r_result     <= 4'd0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_phase      <= w_phase_nxt;
      r_phase_cnt  <= w_phase_cnt_nxt;
      r_period_cnt <= w_period_cnt_nxt;
      r_result     <= w_result_nxt;
      r_done       <= w_done_nxt;
    end
  end

  // Next-state logic: start beats stop, stop beats the phase/period counters.
  always_comb begin
    w_state_nxt      = r_state;
    w_phase_nxt      = r_phase;
    w_phase_cnt_nxt  = r_phase_cnt;
    w_period_cnt_nxt = r_period_cnt;
    w_result_nxt     = r_result;
    w_done_nxt       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt      = S_RUN;
          w_phase_nxt      = 3'd0;
          w_phase_cnt_nxt  = {CNT_W{1'b0}};
          w_period_cnt_nxt = {CNT_W{1'b0}};
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (i_start) begin
          w_phase_nxt      = 3'd0;
          w_phase_cnt_nxt  = {CNT_W{1'b0}};
          w_period_cnt_nxt = {CNT_W{1'b0}};
        end else if (i_stop) begin
          w_state_nxt      = S_FINISH;
          w_phase_cnt_nxt  = {CNT_W{1'b0}};
          w_period_cnt_nxt = {CNT_W{1'b0}};
        end else if (w_phase_end) begin
          w_phase_cnt_nxt  = {CNT_W{1'b0}};
          w_period_cnt_nxt = {CNT_W{1'b0}};
          if (r_phase == 3'(NUM_PHASES - 1)) begin
            w_state_nxt = S_FINISH;
          end else begin
            w_phase_nxt = r_phase + 3'd1;
          end
        end else begin
          w_phase_cnt_nxt = r_phase_cnt + CNT_W'(1);
          if (w_period_end) begin
            w_period_cnt_nxt = {CNT_W{1'b0}};
          end else begin
            w_period_cnt_nxt = r_period_cnt + CNT_W'(1);
          end
        end
      end
      S_FINISH: begin
        if (i_start) begin
          w_state_nxt      = S_RUN;
          w_phase_nxt      = 3'd0;
          w_phase_cnt_nxt  = {CNT_W{1'b0}};
          w_period_cnt_nxt = {CNT_W{1'b0}};
        end else begin
          // No steps are issued here, so i_rand is settled for the capture.
          w_state_nxt  = S_IDLE;
          w_phase_nxt  = 3'd0;
          w_result_nxt = i_rand;
          w_done_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt      = S_IDLE;
        w_phase_nxt      = 3'd0;
        w_phase_cnt_nxt  = {CNT_W{1'b0}};
        w_period_cnt_nxt = {CNT_W{1'b0}};
      end
    endcase
  end

  assign o_step   = (r_state == S_RUN) && (r_period_cnt == {CNT_W{1'b0}});
  assign o_busy   = (r_state != S_IDLE);
  assign o_phase  = r_phase;
  assign o_result = r_result;
  assign o_done   = r_done;

endmodule

// File: tb/tb_rng_roll_scheduler.sv
// tb_rng_roll_scheduler: directed checks of the roll scheduler with a small
// LFSR model (taps [3]^[0], seed 3) stepped by o_step.
module tb_rng_roll_scheduler;

  localparam int PL = 16;
  localparam int BP = 2;
  localparam int NP = 3;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [3:0] lfsr;
  logic       o_step;
  logic       o_busy;
  logic [2:0] o_phase;
  logic [3:0] o_result;
  logic       o_done;

  int n_total = 0;
  int n_pass  = 0;
  int n_steps = 0;

  rng_roll_scheduler #(
    .CNT_W(24), .PHASE_LEN(PL), .BASE_PERIOD(BP), .NUM_PHASES(NP)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_rand(lfsr),
    .o_step(o_step), .o_busy(o_busy), .o_phase(o_phase), .o_result(o_result),
    .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LFSR model and step counter, both cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr    <= 4'd3;
      n_steps <= 0;
    end else if (o_step) begin
      lfsr    <= {lfsr[3] ^ lfsr[0], lfsr[3:1]};
      n_steps <= n_steps + 1;
    end
  end

  function automatic logic [3:0] lfsr_after(input int n);
    logic [3:0] v;
    v = 4'd3;
    for (int i = 0; i < n; i++) v = {v[3] ^ v[0], v[3:1]};
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0;
    stop  = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Checks RUN cycles c0..c1 of an uninterrupted roll, advancing one cycle each.
  task automatic expect_roll(input int c0, input int c1);
    for (int c = c0; c <= c1; c++) begin
      int ph;
      int off;
      ph  = (c - 1) / PL;
      off = (c - 1) % PL;
      check("run_step",  int'(o_step),  int'((off % (BP << ph)) == 0));
      check("run_phase", int'(o_phase), ph);
      check("run_busy",  int'(o_busy),  1);
      check("run_done",  int'(o_done),  0);
      tick();
    end
  endtask

  typedef struct {
    logic       start;
    logic       stop;
    logic       busy;
    logic       step;
    logic [2:0] phase;
    logic       done;
    logic [3:0] result;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [3:0] f5;
    int idle_pulses;
    f5 = lfsr_after(5);

    // Stop at cycle 10, then stop while idle; entry i drives cycle i, checks cycle i+1.
    tbl[0] = '{start: 1'b1, stop: 1'b0, busy: 1'b1, step: 1'b1, phase: 3'd0, done: 1'b0, result: 4'd0};
    for (int c = 1; c <= 9; c++)
      tbl[c] = '{start: 1'b0, stop: 1'b0, busy: 1'b1, step: ((c + 1) % 2 == 1), phase: 3'd0,
                 done: 1'b0, result: 4'd0};
    tbl[10] = '{start: 1'b0, stop: 1'b1, busy: 1'b1, step: 1'b0, phase: 3'd0, done: 1'b0, result: 4'd0};
    tbl[11] = '{start: 1'b0, stop: 1'b0, busy: 1'b0, step: 1'b0, phase: 3'd0, done: 1'b1, result: f5};
    tbl[12] = '{start: 1'b0, stop: 1'b1, busy: 1'b0, step: 1'b0, phase: 3'd0, done: 1'b0, result: f5};
    tbl[13] = '{start: 1'b0, stop: 1'b1, busy: 1'b0, step: 1'b0, phase: 3'd0, done: 1'b0, result: f5};

    do_reset();
    check("rst_busy",   int'(o_busy),   0);
    check("rst_step",   int'(o_step),   0);
    check("rst_phase",  int'(o_phase),  0);
    check("rst_done",   int'(o_done),   0);
    check("rst_result", int'(o_result), 0);

    for (int i = 0; i < 14; i++) begin
      start = tbl[i].start;
      stop  = tbl[i].stop;
      tick();
      check($sformatf("vec%0d_busy", i),   int'(o_busy),   int'(tbl[i].busy));
      check($sformatf("vec%0d_step", i),   int'(o_step),   int'(tbl[i].step));
      check($sformatf("vec%0d_phase", i),  int'(o_phase),  int'(tbl[i].phase));
      check($sformatf("vec%0d_done", i),   int'(o_done),   int'(tbl[i].done));
      check($sformatf("vec%0d_result", i), int'(o_result), int'(tbl[i].result));
    end
    start = 1'b0;
    stop  = 1'b0;
    check("stop_steps", n_steps, 5);

    // Full uninterrupted roll.
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_roll(1, 48);
    check("fin_busy", int'(o_busy), 1);
    check("fin_step", int'(o_step), 0);
    check("fin_done", int'(o_done), 0);
    tick();
    check("roll_done",   int'(o_done),   1);
    check("roll_result", int'(o_result), int'(lfsr_after(14)));
    check("roll_busy",   int'(o_busy),   0);
    check("roll_phase",  int'(o_phase),  0);
    check("roll_steps",  n_steps,        14);
    tick();
    check("post_done",   int'(o_done),   0);
    check("post_result", int'(o_result), int'(lfsr_after(14)));

    // Asynchronous reset in the middle of a second roll.
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_roll(1, 29);
    rst_n = 1'b0;
    #2;
    check("arst_busy",   int'(o_busy),   0);
    check("arst_step",   int'(o_step),   0);
    check("arst_done",   int'(o_done),   0);
    check("arst_result", int'(o_result), 0);
    tick();
    rst_n = 1'b1;
    idle_pulses = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (o_step || o_busy || o_done) idle_pulses++;
    end
    check("arst_quiet", idle_pulses, 0);

    // Restart at cycle 20 (phase 1), then a full roll.
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_roll(1, 19);
    check("rs_phase20", int'(o_phase), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_roll(1, 48);
    check("rs_fin_done", int'(o_done), 0);
    check("rs_fin_busy", int'(o_busy), 1);
    tick();
    check("rs_done",   int'(o_done),   1);
    check("rs_result", int'(o_result), int'(lfsr_after(23)));
    check("rs_steps",  n_steps,        23);

    // Start and stop together restarts; start during FINISH resumes RUN.
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_roll(1, 4);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    expect_roll(1, 48);
    check("ss_fin_busy", int'(o_busy), 1);
    check("ss_fin_step", int'(o_step), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("sf_done",   int'(o_done),   0);
    check("sf_busy",   int'(o_busy),   1);
    check("sf_step",   int'(o_step),   1);
    check("sf_result", int'(o_result), 0);
    expect_roll(1, 10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
